tpu_tile_scheduler: RTL
=======================

# tpu_tile_scheduler

Control sequencer for the 4x4 output-stationary TPU datapath. It accepts a K/M/N job, walks every 4x4 output tile, and for each tile issues the A/B global-buffer read addresses, the array clear/feed strobes and the drain wait. It then writes the four result rows into the C buffer. It sits between the TPU top-level handshake (`in_valid`/`busy`) and the systolic array plus buffer ports.

## Interface
Parameters:
- `DRAIN_CYC`, default 8: cycles between the last array feed and the first C row write; covers the array skew and pipeline depth.
- `IDX_W`, default 16: width of the buffer index buses.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `in_valid`  input  1  job start strobe; K/M/N are valid in the same cycle.
- `K`, `M`, `N`  input  8 each  job dimensions: A is MxK, B is KxN, C is MxN.
- `busy`  output  1  high while a job is in flight.
- `A_wr_en`, `B_wr_en`  output  1 each  tied 0; this block only reads A and B.
- `A_index`, `B_index`  output  IDX_W each  read addresses; buffers have 1-cycle read latency.
- `arr_clear`  output  1  zeroes the PE accumulators; coincides with the first feed of a tile.
- `arr_feed_valid`  output  1  the A/B data words arriving this cycle are valid.
- `arr_row_sel`  output  2  array result row muxed onto `C_data_in`.
- `C_wr_en`  output  1  C buffer write strobe.
- `C_index`  output  IDX_W  C write address.

## Operation
- Buffer layout:
  - A word = 4 int8 from rows 4mb..4mb+3 at column k; address mb*K+k.
  - B word = 4 int8 from columns 4nb..4nb+3 at row k; address nb*K+k.
  - C word = 4 int32 from one row, columns 4nb..4nb+3; address row*NB+nb.
- Tile counts: MB=(M+3)>>2 and NB=(N+3)>>2, computed from the latched M and N.
- Tile order: mb outer, nb inner, both ascending from 0.
- FSM states:
  - IDLE: on `in_valid`=1 with K, M, N all nonzero, latch K/M/N and go to FEED with mb=nb=k=0. `in_valid` with any zero dimension is ignored and the block stays in IDLE.
  - FEED: one cycle per k=0..K-1. Drives A_index=mb*K+k and B_index=nb*K+k. After k=K-1, go to DRAIN.
  - DRAIN: DRAIN_CYC+1 cycles. The first DRAIN cycle carries the delayed last `arr_feed_valid`. Then go to WRITE.
  - WRITE: 4 cycles, r=0..3. `arr_row_sel`=r and C_index=(4mb+r)*NB+nb. `C_wr_en`=1 only when 4mb+r < M; padded rows are skipped but still take their cycle. After r=3, advance the tile: nb+1 with wrap to 0 and mb+1. Go to FEED for the next tile, or to IDLE after the last tile.
- `arr_feed_valid` is the FEED-state indicator delayed by one register, aligning it with the buffer read data. `arr_clear` is the delayed "k==0" indicator.
- Index arithmetic is unsigned. All products fit in 16 bits (max 63*255+254 and 255*64+63), so there is no truncation.
- `in_valid` outside IDLE is ignored. K/M/N changing mid-job has no effect.

## Timing
- Reset: all outputs are 0, state is IDLE and counters are 0. This applies at any time, including mid-job: the same edge aborts the job and no further C writes occur.
- In the tile descriptions below, edge e0 is the edge that samples `in_valid`, and cycle c0 is the cycle following e0.
- Job start:
  - `busy`=1 from cycle c0.
  - First A/B index is in cycle c0.
  - First `arr_feed_valid` and `arr_clear` are in cycle c0+1.
- Per-tile length: K+1+DRAIN_CYC+4 cycles. Within a tile starting at cycle t:
  - Indices are in cycles t..t+K-1.
  - Feeds are in cycles t+1..t+K.
  - Writes are in cycles t+K+DRAIN_CYC+1..t+K+DRAIN_CYC+4.
  - The next tile's first index is in the cycle after the last write.
- Job end: `busy` falls in the cycle after the final WRITE cycle, which is also the first IDLE cycle. A new `in_valid` is accepted in that cycle.
- Outside FEED, A_index and B_index are 0. Outside WRITE, `arr_row_sel` and C_index are 0.

## Test plan
- Single tile, K=M=N=4, DRAIN_CYC=8, `in_valid` at e0:
  - A/B index 0..3 in cycles c0..c0+3.
  - `arr_feed_valid` in cycles c0+1..c0+4; `arr_clear` only in cycle c0+1.
  - C writes to indices 0,1,2,3 in cycles c0+13..c0+16.
  - `busy` falls in cycle c0+17.
- Tile order, K=2, M=N=8:
  - Tiles run in the order (0,0),(0,1),(1,0),(1,1).
  - Tile (1,1) reads A 2,3 and B 2,3, and writes C 9,11,13,15.
  - Total busy time is 4*15 cycles.
- Row padding, K=1, M=5, N=4:
  - Tile 0 writes C 0..3.
  - Tile 1 writes only C 4 with `arr_row_sel`=0. It spends 3 idle WRITE cycles with `C_wr_en`=0 and `arr_row_sel` at 1,2,3.
- Rejected starts:
  - `in_valid` with K=0: `busy` stays 0 and all outputs stay 0.
  - `in_valid` pulsed mid-job with other dimensions: the current job's addresses and length are unchanged.
- Back-to-back jobs: assert `in_valid` in the first IDLE cycle after a job. The next job is accepted and `busy` is low for exactly that one cycle.
- Reset mid-job: drop `rst_n` during DRAIN. On the next edge all outputs are 0 and the state is IDLE, with no C writes afterwards. A new job then runs normally.

Source files
------------

// File: rtl/tpu_tile_scheduler.sv
// tpu_tile_scheduler: walks every 4x4 output tile of a K/M/N job, issuing the
// A/B read addresses, array clear/feed strobes, the drain wait and the four
// C row writes for each tile. Tiles run mb-outer, nb-inner.
module tpu_tile_scheduler #(
    parameter int DRAIN_CYC = 8,
    parameter int IDX_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       K,
    input  logic [7:0]       M,
    input  logic [7:0]       N,
    output logic             busy,
    output logic             A_wr_en,
    output logic             B_wr_en,
    output logic [IDX_W-1:0] A_index,
    output logic [IDX_W-1:0] B_index,
    output logic             arr_clear,
    output logic             arr_feed_valid,
    output logic [1:0]       arr_row_sel,
    output logic             C_wr_en,
    output logic [IDX_W-1:0] C_index
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, WRITE} state_t;

    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC);

    state_t      state, state_nx;
    logic [7:0]  k_len, m_len, n_len;
    logic [7:0]  k_len_nx, m_len_nx, n_len_nx;
    logic [6:0]  mb, nb, mb_nx, nb_nx;
    logic [7:0]  k_cnt, k_cnt_nx;
    logic [15:0] drain_cnt, drain_cnt_nx;
    logic [1:0]  r_cnt, r_cnt_nx;
    logic        feed_d, clear_d;
    logic        feed_now, clear_now;
    logic [6:0]  mb_total, nb_total;
    logic [7:0]  row;
    logic        last_tile;

    // Tile counts round the latched dimensions up to whole 4-wide blocks;
    // the 9-bit sum keeps M=253..255 from wrapping.
    assign mb_total  = 7'((9'(m_len) + 9'd3) >> 2);
    assign nb_total  = 7'((9'(n_len) + 9'd3) >> 2);
    assign row       = {mb[5:0], 2'b00} + {6'd0, r_cnt};
    assign last_tile = (mb == mb_total - 7'd1) && (nb == nb_total - 7'd1);

    assign busy           = (state != IDLE);
    assign A_wr_en        = 1'b0;
    assign B_wr_en        = 1'b0;
    assign arr_feed_valid = feed_d;
    assign arr_clear      = clear_d;

    // State register plus the one-cycle delay that lines feed/clear up with
    // the buffer read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_len     <= '0;
            m_len     <= '0;
            n_len     <= '0;
            mb        <= '0;
            nb        <= '0;
            k_cnt     <= '0;
            drain_cnt <= '0;
            r_cnt     <= '0;
            feed_d    <= 1'b0;
            clear_d   <= 1'b0;
        end else begin
            state     <= state_nx;
            k_len     <= k_len_nx;
            m_len     <= m_len_nx;
            n_len     <= n_len_nx;
            mb        <= mb_nx;
            nb        <= nb_nx;
            k_cnt     <= k_cnt_nx;
            drain_cnt <= drain_cnt_nx;
            r_cnt     <= r_cnt_nx;
            feed_d    <= feed_now;
            clear_d   <= clear_now;
        end
    end

    // Next-state, counter updates and the address/strobe outputs per state.
    always_comb begin
        state_nx     = state;
        k_len_nx     = k_len;
        m_len_nx     = m_len;
        n_len_nx     = n_len;
        mb_nx        = mb;
        nb_nx        = nb;
        k_cnt_nx     = k_cnt;
        drain_cnt_nx = drain_cnt;
        r_cnt_nx     = r_cnt;
        feed_now     = 1'b0;
        clear_now    = 1'b0;
        A_index      = '0;
        B_index      = '0;
        arr_row_sel  = 2'd0;
        C_wr_en      = 1'b0;
        C_index      = '0;
        case (state)
            IDLE: begin
                if (in_valid && (K != 8'd0) && (M != 8'd0) && (N != 8'd0)) begin
                    k_len_nx = K;
                    m_len_nx = M;
                    n_len_nx = N;
                    mb_nx    = '0;
                    nb_nx    = '0;
                    k_cnt_nx = '0;
                    state_nx = FEED;
                end
            end
            FEED: begin
                A_index   = IDX_W'(mb) * IDX_W'(k_len) + IDX_W'(k_cnt);
                B_index   = IDX_W'(nb) * IDX_W'(k_len) + IDX_W'(k_cnt);
                feed_now  = 1'b1;
                clear_now = (k_cnt == 8'd0);
                if (k_cnt == k_len - 8'd1) begin
                    k_cnt_nx     = '0;
                    drain_cnt_nx = '0;
                    state_nx     = DRAIN;
                end else begin
                    k_cnt_nx = k_cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    r_cnt_nx = 2'd0;
                    state_nx = WRITE;
                end else begin
                    drain_cnt_nx = drain_cnt + 16'd1;
                end
            end
            WRITE: begin
                arr_row_sel = r_cnt;
                C_index     = IDX_W'(row) * IDX_W'(nb_total) + IDX_W'(nb);
                C_wr_en     = (row < m_len);
                if (r_cnt == 2'd3) begin
                    k_cnt_nx = '0;
                    if (last_tile) begin
                        mb_nx    = '0;
                        nb_nx    = '0;
                        state_nx = IDLE;
                    end else begin
                        if (nb == nb_total - 7'd1) begin
                            nb_nx = '0;
                            mb_nx = mb + 7'd1;
                        end else begin
                            nb_nx = nb + 7'd1;
                        end
                        state_nx = FEED;
                    end
                end else begin
                    r_cnt_nx = r_cnt + 2'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
